slow_clk_monitor: RTL and testbench

SLOW_CLK_MONITOR -- requirements
Module: slow_clk_monitor

---
 rtl/slow_clk_monitor.sv | 196 +++++++++++++++++++
 tb/tb_slow_clk_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// Slow clock / tick monitor: synchronizes clk_in, detects edges, measures the
// rise-to-rise period and flags loss. Optional glitch filter: SLOW_CLK_MONITOR_GLITCH_FILTER_EN.
module slow_clk_monitor #(
    parameter int unsigned EXPECTED = 50000000,
    parameter int unsigned TOL      = 500,
    parameter int unsigned TIMEOUT  = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_in,
    input  logic        enable,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        in_range,
    output logic        lost
);

    localparam logic [31:0] EXPECTED_C = 32'(EXPECTED);
    localparam logic [31:0] TOL_C      = 32'(TOL);
    localparam logic [31:0] TIMEOUT_C  = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] period_q;
    logic        rise_pulse_q;
    logic        fall_pulse_q;
    logic        period_valid_q;
    logic        in_range_q;
    logic        lost_q;
    logic        lvl_d;
    logic        rise_d;
    logic        fall_d;

    // |v - EXPECTED| <= TOL without signed arithmetic
    function automatic logic within_tol(input logic [31:0] v);
        logic [31:0] diff;
        if (v >= EXPECTED_C) begin
            diff = v - EXPECTED_C;
        end else begin
            diff = EXPECTED_C - v;
        end
        return (diff <= TOL_C);
    endfunction

`ifdef SLOW_CLK_MONITOR_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    // Synchronizer, filter sample history and filtered previous level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clk_in;
            sync2_q <= sync1_q;
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            prev_q  <= lvl_d;
        end
    end

    // Filtered level follows the input only after three equal samples
    always_comb begin
        lvl_d = prev_q;
        if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
            lvl_d = sync2_q;
        end else begin
            lvl_d = prev_q;
        end
    end
`else
    // Synchronizer and previous-level register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clk_in;
            sync2_q <= sync1_q;
            prev_q  <= lvl_d;
        end
    end

    // Synchronized level drives edge detection directly
    always_comb begin
        lvl_d = sync2_q;
    end
`endif

    // Edge detection and saturating counter increment
    always_comb begin
        rise_d = lvl_d & ~prev_q;
        fall_d = ~lvl_d & prev_q;
        if (cnt_q == 32'hFFFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Monitor FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 32'd0;
            period_q       <= 32'd0;
            rise_pulse_q   <= 1'b0;
            fall_pulse_q   <= 1'b0;
            period_valid_q <= 1'b0;
            in_range_q     <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            rise_pulse_q   <= rise_d & enable & (state_q != ST_IDLE);
            fall_pulse_q   <= fall_d & enable & (state_q != ST_IDLE);
            period_valid_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= 32'd0;
                lost_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                        cnt_q   <= 32'd0;
                        lost_q  <= 1'b0;
                    end
                    ST_ARM: begin
                        if (rise_d) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= 32'd1;
                        end else if (cnt_q == TIMEOUT_C) begin
                            state_q <= ST_LOST;
                            lost_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_MEASURE: begin
                        // A rise in the timeout cycle still counts as a measurement
                        if (rise_d) begin
                            period_q       <= cnt_q;
                            period_valid_q <= 1'b1;
                            in_range_q     <= within_tol(cnt_q);
                            cnt_q          <= 32'd1;
                        end else if (cnt_q == TIMEOUT_C) begin
                            state_q <= ST_LOST;
                            lost_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_LOST: begin
                        if (rise_d) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= 32'd1;
                            lost_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 32'd0;
                        lost_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign in_range     = in_range_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor (EXPECTED=10, TOL=1, TIMEOUT=30) against a
// timestamp-based reference model; honours SLOW_CLK_MONITOR_GLITCH_FILTER_EN.
module tb_slow_clk_monitor;

    localparam int EXP_P = 10;
    localparam int TOL_P = 1;
    localparam int TO_P  = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_in = 1'b0;
    logic        enable = 1'b0;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [31:0] period;
    logic        period_valid;
    logic        in_range;
    logic        lost;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: sample history, modes and timestamps
    bit [4:0]    samp;
    bit          m_lvl;
    int          m_mode;   // 0 off, 1 waiting first rise, 2 running, 3 gone
    int          m_n;
    int          t_arm;
    int          t_rise;
    bit          e_rise, e_fall, e_pv, e_inr, e_lost;
    logic [31:0] e_per;
    int          rise_cnt;
    int          pv_cnt;

    slow_clk_monitor #(.EXPECTED(EXP_P), .TOL(TOL_P), .TIMEOUT(TO_P)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_in       (clk_in),
        .enable       (enable),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .in_range     (in_range),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        samp   = 5'd0;
        m_lvl  = 1'b0;
        m_mode = 0;
        m_n    = 0;
        t_arm  = 0;
        t_rise = 0;
        e_rise = 1'b0;
        e_fall = 1'b0;
        e_pv   = 1'b0;
        e_inr  = 1'b0;
        e_lost = 1'b0;
        e_per  = 32'd0;
    endtask

    // One clk edge of the reference model, using inputs present at that edge
    task automatic model_edge(input bit en, input bit s);
        bit lvl, r, f;
        int d;
        m_n  = m_n + 1;
        samp = {samp[3:0], s};
`ifdef SLOW_CLK_MONITOR_GLITCH_FILTER_EN
        lvl = ((samp[2] == samp[3]) && (samp[3] == samp[4])) ? samp[2] : m_lvl;
`else
        lvl = samp[2];
`endif
        r = lvl & ~m_lvl;
        f = ~lvl & m_lvl;
        m_lvl  = lvl;
        e_rise = r && en && (m_mode != 0);
        e_fall = f && en && (m_mode != 0);
        e_pv   = 1'b0;
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            t_arm  = m_n;
        end else if (m_mode == 1) begin
            if (r) begin
                m_mode = 2;
                t_rise = m_n;
            end else if (m_n - t_arm - 1 == TO_P) begin
                m_mode = 3;
            end
        end else if (m_mode == 2) begin
            if (r) begin
                e_pv  = 1'b1;
                e_per = 32'(m_n - t_rise);
                d     = (m_n - t_rise) - EXP_P;
                if (d < 0) d = -d;
                e_inr  = (d <= TOL_P);
                t_rise = m_n;
            end else if (m_n - t_rise == TO_P) begin
                m_mode = 3;
            end
        end else begin
            if (r) begin
                m_mode = 2;
                t_rise = m_n;
            end
        end
        e_lost = (m_mode == 3);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (got === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rise_pulse",   32'(rise_pulse),   32'(e_rise));
        chk("fall_pulse",   32'(fall_pulse),   32'(e_fall));
        chk("period",       period,            e_per);
        chk("period_valid", 32'(period_valid), 32'(e_pv));
        chk("in_range",     32'(in_range),     32'(e_inr));
        chk("lost",         32'(lost),         32'(e_lost));
        if (rise_pulse === 1'b1) rise_cnt = rise_cnt + 1;
        if (period_valid === 1'b1) pv_cnt = pv_cnt + 1;
    endtask

    task automatic cyc(input bit ci, input bit en);
        clk_in = ci;
        enable = en;
        @(posedge clk);
        if (rst) model_edge(en, ci);
        #1;
        check_all();
    endtask

    task automatic run_period(input int p, input int hi, input bit en);
        for (int i = 0; i < hi; i++) cyc(1'b1, en);
        for (int i = 0; i < p - hi; i++) cyc(1'b0, en);
    endtask

    initial begin
        int p;
        int hi;
        int lat;
        model_reset();
        rise_cnt = 0;
        pv_cnt   = 0;

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);

        // Nominal period 10
        for (int i = 0; i < 5; i++) run_period(10, 5, 1'b1);
        chk("nominal_period", period, 32'd10);
        chk("nominal_in_range", 32'(in_range), 32'd1);

        // Long and short periods
        for (int i = 0; i < 3; i++) run_period(13, 6, 1'b1);
        chk("period_13", period, 32'd13);
        chk("in_range_13", 32'(in_range), 32'd0);
        for (int i = 0; i < 3; i++) run_period(9, 4, 1'b1);
        chk("in_range_9", 32'(in_range), 32'd1);

        // Randomized periods and duty cycles
        for (int k = 0; k < 12; k++) begin
            p  = int'($urandom_range(6, 16));
            hi = int'($urandom_range(3, p - 3));
            run_period(p, hi, 1'b1);
        end

        // clk_in stuck low -> lost, then recovery
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1);
        chk("lost_after_stuck", 32'(lost), 32'd1);
        for (int i = 0; i < 4; i++) run_period(10, 5, 1'b1);
        chk("lost_cleared", 32'(lost), 32'd0);

        // Enable dropped mid-period, clk_in keeps toggling
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        rise_cnt = 0;
        for (int i = 0; i < 20; i++) cyc(((i / 4) % 2) == 0, 1'b0);
        chk("no_pulse_idle", 32'(rise_cnt), 32'd0);
        for (int i = 0; i < 4; i++) run_period(11, 5, 1'b1);

        // Timeout while armed
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1);
        chk("lost_from_arm", 32'(lost), 32'd1);
        for (int i = 0; i < 3; i++) run_period(10, 5, 1'b1);

        // Asynchronous reset mid-measurement with clk_in high
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        rst = 1'b1;
        rise_cnt = 0;
        pv_cnt   = 0;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
        chk("post_reset_rises", 32'(rise_cnt), 32'd1);
        chk("post_reset_no_pv", 32'(pv_cnt), 32'd0);
        for (int i = 0; i < 4; i++) run_period(12, 6, 1'b1);

`ifdef SLOW_CLK_MONITOR_GLITCH_FILTER_EN
        // Short high glitch is filtered; a 3-cycle pulse gets through with extra latency
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
        rise_cnt = 0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
        chk("glitch_ignored", 32'(rise_cnt), 32'd0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc((i <= 3), 1'b1);
            if (rise_pulse === 1'b1 && lat == 0) lat = i;
        end
        chk("filter_latency", 32'(lat), 32'd5);
`else
        // Single-cycle high pulse is seen with three-cycle latency
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc((i == 1), 1'b1);
            if (rise_pulse === 1'b1 && lat == 0) lat = i;
        end
        chk("edge_latency", 32'(lat), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
